fadder_accum: RTL and testbench
===============================

FADDER_ACCUM -- requirements
Module: fadder_accum

Interface
REQ-001 Parameter SUM_W, default 4, width of the incoming adder sum.
REQ-002 Parameter ACC_W, default 8, accumulator width; the block SHALL support ACC_W >= SUM_W+1.
REQ-003 Parameter CNT_W, default 4, width of the batch-length field.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  single-cycle pulse that begins a batch.
REQ-007 len  input  CNT_W  number of operands in the batch, sampled on start; 0 means 2^CNT_W.
REQ-008 in_valid  input  1  upstream adder result valid.
REQ-009 in_sum  input  SUM_W  adder sum bits.
REQ-010 in_cout  input  1  adder carry-out.
REQ-011 in_ready  output  1  block accepts an operand this cycle.
REQ-012 out_valid  output  1  batch result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_acc  output  ACC_W  accumulated batch total.
REQ-015 out_ovf  output  1  sticky overflow flag for the batch.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The block SHALL implement the FSM states IDLE, ACCUM and HOLD, encoded in registers.
REQ-018 IDLE: in_ready=0, out_valid=0; on start=1 latch len into the remaining count, clear acc and ovf, go to ACCUM next cycle.
REQ-019 The block SHALL ignore start in ACCUM and HOLD: no relatch, no clear.
REQ-020 ACCUM: in_ready=1 combinationally from state only, with no dependency on in_valid.
REQ-021 A beat SHALL occur when in_valid and in_ready are both 1 on a rising edge; in_valid without in_ready is not a beat.
REQ-022 On a beat the operand SHALL be {in_cout,in_sum}, zero-extended to ACC_W, added to acc modulo 2^ACC_W.
REQ-023 out_ovf SHALL set on a beat whose addition carries out of bit ACC_W-1, and SHALL stay set until the next start or reset.
REQ-024 The remaining count SHALL decrement by one per beat; idle cycles in ACCUM (in_valid=0) SHALL leave acc, count and ovf unchanged.
REQ-025 On the beat that consumes the final operand, the FSM SHALL go to HOLD, and out_valid SHALL rise in the cycle after that beat (latency 1 from last beat).
REQ-026 HOLD: in_ready=0; out_valid=1; out_acc and out_ovf SHALL be stable until the result is taken.
REQ-027 In HOLD with out_ready=1 the result SHALL be taken on that edge and the FSM SHALL return to IDLE, with out_valid=0 the next cycle.
REQ-028 out_ready SHALL have no effect outside HOLD.
REQ-029 out_acc SHALL show the live accumulator in every state; it has meaning to consumers only while out_valid=1.
REQ-030 A batch of length 2^CNT_W (len=0) SHALL accept exactly 2^CNT_W beats.
REQ-031 Minimum batch turnaround SHALL be len beats + 1 HOLD cycle + 1 IDLE cycle.

Reset
REQ-032 When rst_n=0, regardless of clk, the block SHALL force state=IDLE, acc=0, count=0, ovf=0.
REQ-033 While rst_n=0, outputs SHALL be in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
REQ-034 Reset asserted mid-batch or in HOLD SHALL discard the partial or pending result with no output beat.
REQ-035 After rst_n rises, the first start SHALL be honoured on the first rising edge.

Verification
REQ-036 Basic batch: start with len=3, then beats {0,0001},{0,0010},{1,0011} (=1,2,19) -> out_valid one cycle after the third beat, out_acc=22, out_ovf=0.
REQ-037 Backpressure: in HOLD, out_ready=0 for 5 cycles then 1 -> out_valid and out_acc stable for all 6 cycles, IDLE on the 7th, no extra beats accepted.
REQ-038 Bubbles and ignored start: len=2, in_valid toggled 1,0,0,1, start pulsed mid-ACCUM -> exactly 2 beats counted, acc not cleared, total correct.
REQ-039 Overflow and wrap: len=0 with 16 beats of {1,1111} (=31 each) -> out_acc=496 mod 256=240, out_ovf=1; next batch len=1 with value 5 -> out_acc=5, out_ovf=0.
REQ-040 Reset mid-batch: rst_n low asynchronously between edges after 2 of 4 beats -> in_ready, out_valid, busy and out_acc are 0 immediately; a fresh len=1 batch of 7 then gives out_acc=7.
REQ-041 Random: random in_valid/out_ready, len 1-15, operands 0-31 against a scoreboard of the mod-2^ACC_W sum plus carry flag -> zero mismatches over 1000 batches.

Source files
------------

// File: rtl/fadder_accum.sv
// Batch accumulator for a ripple-adder result stream.
// Sums {cout,sum} operands over a counted batch and holds the total.
module fadder_accum #(
    parameter int SUM_W = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             in_cout,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W:0] ONE = 1;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W:0]   count;
    logic             ovf;
    logic [ACC_W:0]   opnd;
    logic [ACC_W:0]   sum;
    logic             beat;

    always_comb begin
        opnd = '0;
        opnd[SUM_W:0] = {in_cout, in_sum};
    end

    // Extra top bit of sum is the carry out of the accumulator.
    assign sum  = {1'b0, acc} + opnd;
    assign beat = (state == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // len of zero encodes a full 2^CNT_W batch
                        count <= {(len == '0), len};
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum[ACC_W-1:0];
                        ovf   <= ovf | sum[ACC_W];
                        count <= count - ONE;
                        if (count == ONE) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_acc   = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_fadder_accum.sv
// Directed and random bench for fadder_accum.
// Expected totals come from a plain integer sum of the batch operands.
module tb_fadder_accum;

    localparam int SUM_W = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [SUM_W-1:0] in_sum;
    logic             in_cout;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             busy;

    int total;
    int bad;
    int exp_acc;
    int exp_ovf;
    logic [4:0] ops [16];

    fadder_accum #(
        .SUM_W(SUM_W),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_sum   (in_sum),
        .in_cout  (in_cout),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
        end
    endtask

    // Per-cycle monitor against the model's batch total.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {in_ready, out_valid, busy, out_ovf}, 0);
            chk("rst_acc", int'(out_acc), 0);
        end else begin
            if (in_ready && out_valid) chk("ready_and_valid", 1, 0);
            if (out_valid) begin
                chk("mon_acc", int'(out_acc), exp_acc);
                chk("mon_ovf", int'(out_ovf), exp_ovf);
                chk("mon_busy", int'(busy), 1);
            end
        end
    end

    task automatic set_model(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(ops[i]);
        exp_acc = s % (1 << ACC_W);
        exp_ovf = (s >= (1 << ACC_W)) ? 1 : 0;
    endtask

    // mode 0: always valid, 1: valid from mask bits, 2: random valid
    task automatic do_batch(
        input int lfield, input int n, input int mode, input int mask,
        input int hold, input bit hold_valid, input bit mid_start,
        input int lit_acc, input int lit_ovf
    );
        int  i;
        int  c;
        bit  v;
        bit  took;
        set_model(n);
        start = 1'b1;
        len   = CNT_W'(lfield);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accum_ready", int'(in_ready), 1);
        chk("accum_busy", int'(busy), 1);
        i = 0;
        c = 0;
        while (i < n && c < 400) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (c < 32) ? mask[c] : 1'b1;
            else v = 1'(($urandom % 2));
            in_valid = v;
            in_sum   = ops[i][3:0];
            in_cout  = ops[i][4];
            out_ready = (mode == 2) ? 1'(($urandom % 2)) : 1'b0;
            if (mid_start && c == 1) begin
                start = 1'b1;
                len   = 4'd5;
            end
            took = v && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (took) i++;
            c++;
        end
        if (c >= 400) chk("beat_timeout", c, 0);
        in_valid  = hold_valid;
        out_ready = 1'b0;
        chk("lat_valid", int'(out_valid), 1);
        chk("hold_ready", int'(in_ready), 0);
        if (lit_acc >= 0) chk("lit_acc", int'(out_acc), lit_acc);
        if (lit_ovf >= 0) chk("lit_ovf", int'(out_ovf), lit_ovf);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_acc", int'(out_acc), exp_acc);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_acc   = 0;
        exp_ovf   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_acc", int'(out_acc), 0);
        @(posedge clk);
        #1;

        // basic batch: 1 + 2 + 19
        ops[0] = 5'b0_0001;
        ops[1] = 5'b0_0010;
        ops[2] = 5'b1_0011;
        do_batch(3, 3, 0, 0, 0, 1'b0, 1'b0, 22, 0);

        // backpressure with in_valid held high in HOLD
        ops[0] = 5'd9;
        ops[1] = 5'd30;
        do_batch(2, 2, 0, 0, 5, 1'b1, 1'b0, 39, 0);

        // bubbles and an ignored start
        ops[0] = 5'd3;
        ops[1] = 5'd4;
        do_batch(2, 2, 1, 9, 0, 1'b0, 1'b1, 7, 0);

        // full-length batch with overflow, then a clean batch
        for (int i = 0; i < 16; i++) ops[i] = 5'b1_1111;
        do_batch(0, 16, 0, 0, 1, 1'b0, 1'b0, 240, 1);
        ops[0] = 5'd5;
        do_batch(1, 1, 0, 0, 0, 1'b0, 1'b0, 5, 0);

        // asynchronous reset after two of four beats
        start = 1'b1;
        len   = 4'd4;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_sum   = 4'd6;
        in_cout  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_acc", int'(out_acc), 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(in_ready), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_acc", int'(out_acc), 0);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        len   = 4'd1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_start", int'(busy), 1);
        ops[0]   = 5'd7;
        set_model(1);
        in_valid = 1'b1;
        in_sum   = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_acc", int'(out_acc), 7);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_rst_idle", int'(busy), 0);

        // random batches
        for (int b = 0; b < 1000; b++) begin
            int n;
            n = $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) ops[i] = 5'($urandom_range(0, 31));
            do_batch(n, n, 2, 0, $urandom_range(0, 3), 1'($urandom % 2),
                     1'($urandom % 2), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
